// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Brief    : Shared state encoding and line-level constants for the UART TX.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic EVEN = 1'b0;
    localparam logic ODD  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sync_fifo
// Brief    : Show-ahead synchronous FIFO; pushes are refused while full.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO refuses the push even if a pop frees a slot on the same edge
    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop  & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_param
// Brief    : Parametrised UART transmitter with TX FIFO, optional parity and
//            1/2 stop bits; one serial bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_param
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    output logic                  ready,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    input  logic                  stop_bits,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int              BCNT_W     = $clog2(DATA_WIDTH);
    localparam logic [BCNT_W-1:0] c_last_bit = BCNT_W'(DATA_WIDTH - 1);

    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [BCNT_W-1:0]     r_bit_cnt;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop2;
    logic                  r_tx;
    logic                  r_busy;

    logic [DATA_WIDTH-1:0] w_fifo_data;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;

    assign ready  = ~w_full;
    assign TX_OUT = r_tx;
    assign busy   = r_busy;

    // Pop from IDLE, or from the final stop cycle for a back-to-back frame
    assign w_pop = ~w_empty & ((r_state == IDLE) ||
                               (r_state == STOP1 && !r_stop2) ||
                               (r_state == STOP2));

    uart_tx_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .i_push  (Data_Valid),
        .i_data  (P_DATA),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_stop2   <= 1'b0;
            r_tx      <= IDLE_LEVEL;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                START: begin
                    r_tx      <= r_shift[0];
                    r_shift   <= r_shift >> 1;
                    r_bit_cnt <= '0;
                    r_state   <= DATA;
                end
                DATA: begin
                    if (r_bit_cnt == c_last_bit) begin
                        r_state <= r_par_en ? PARITY : STOP1;
                        r_tx    <= r_par_en ? r_par_bit : STOP_BIT;
                    end else begin
                        r_tx      <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
                    end
                end
                PARITY: begin
                    r_state <= STOP1;
                    r_tx    <= STOP_BIT;
                end
                STOP1: begin
                    r_state <= r_stop2 ? STOP2 : IDLE;
                    r_tx    <= STOP_BIT;
                    r_busy  <= r_stop2;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase

            // Loading a new word overrides whatever the case chose above
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_par_en  <= parity_enable;
                r_par_bit <= (parity_type == EVEN) ? (^w_fifo_data) : ~(^w_fifo_data);
                r_stop2   <= stop_bits;
                r_state   <= START;
                r_tx      <= START_BIT;
                r_busy    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
